cmdsender_module: RTL and testbench

Host-side command initiator for the UART calculator link. It accepts one ALU request (opcode, operand A, operand B) from a local controller and pushes it as three bytes into the UART TX FIFO. It then pops the one-byte result from the UART RX FIFO and hands it back with a done pulse. It sits at the opposite end of the link from the board-side interface that consumes opcode/A/B bytes and returns the result byte, and it is used for loopback testbenches and for a second FPGA acting as host.

---
 rtl/cmdsender_module.sv | 157 +++++++++++++++
 tb/tb_cmdsender_module.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cmdsender_module.sv
// Host-side UART calculator command initiator: pushes op/A/B into the TX FIFO,
// then pops one result byte from the RX FIFO (or gives up after a timeout).
module cmdsender_module #(
   parameter int NB_CMDSENDER_DATA = 8,
   parameter int NB_CMDSENDER_OP   = 6,
   parameter int CMDSENDER_TIMEOUT = 50000
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic                         i_cmdsender_START,
   input  logic [NB_CMDSENDER_OP-1:0]   i_cmdsender_OP,
   input  logic [NB_CMDSENDER_DATA-1:0] i_cmdsender_DATAA,
   input  logic [NB_CMDSENDER_DATA-1:0] i_cmdsender_DATAB,
   input  logic                         i_cmdsender_FULL,
   input  logic                         i_cmdsender_EMPTY,
   input  logic [NB_CMDSENDER_DATA-1:0] i_cmdsender_READDATA,
   output logic                         o_cmdsender_WRITE,
   output logic [NB_CMDSENDER_DATA-1:0] o_cmdsender_WRITEDATA,
   output logic                         o_cmdsender_READ,
   output logic [NB_CMDSENDER_DATA-1:0] o_cmdsender_RESULT,
   output logic                         o_cmdsender_DONE,
   output logic                         o_cmdsender_TIMEOUT,
   output logic                         o_cmdsender_BUSY
);

   localparam int CNT_W = (CMDSENDER_TIMEOUT > 0) ? $clog2(CMDSENDER_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(CMDSENDER_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND_OP  = 3'd1,
      ST_SEND_A   = 3'd2,
      ST_SEND_B   = 3'd3,
      ST_WAIT_RES = 3'd4,
      ST_FINISH   = 3'd5
   } state_e;

   state_e                       state_q, state_d;
   logic [NB_CMDSENDER_OP-1:0]   op_q, op_d;
   logic [NB_CMDSENDER_DATA-1:0] a_q, a_d;
   logic [NB_CMDSENDER_DATA-1:0] b_q, b_d;
   logic [NB_CMDSENDER_DATA-1:0] result_q, result_d;
   logic                         flag_q, flag_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;

   logic                         write_s;
   logic [NB_CMDSENDER_DATA-1:0] wdata_s;
   logic                         read_s;
   logic                         done_s;
   logic                         tout_s;

   // State register and latched request/result fields.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         flag_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         flag_q   <= flag_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state and FIFO handshake decode; a send state only advances on a real push.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      flag_d   = flag_q;
      cnt_d    = cnt_q;
      write_s  = 1'b0;
      wdata_s  = '0;
      read_s   = 1'b0;
      done_s   = 1'b0;
      tout_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (i_cmdsender_START) begin
               op_d    = i_cmdsender_OP;
               a_d     = i_cmdsender_DATAA;
               b_d     = i_cmdsender_DATAB;
               flag_d  = 1'b0;
               state_d = ST_SEND_OP;
            end else begin
               read_s = ~i_cmdsender_EMPTY;
            end
         end
         ST_SEND_OP: begin
            write_s = ~i_cmdsender_FULL;
            wdata_s = NB_CMDSENDER_DATA'(op_q);
            if (write_s) state_d = ST_SEND_A;
            else         state_d = ST_SEND_OP;
         end
         ST_SEND_A: begin
            write_s = ~i_cmdsender_FULL;
            wdata_s = a_q;
            if (write_s) state_d = ST_SEND_B;
            else         state_d = ST_SEND_A;
         end
         ST_SEND_B: begin
            write_s = ~i_cmdsender_FULL;
            wdata_s = b_q;
            if (write_s) begin
               cnt_d   = '0;
               state_d = ST_WAIT_RES;
            end else begin
               state_d = ST_SEND_B;
            end
         end
         ST_WAIT_RES: begin
            // A byte present on the limit cycle still counts as a result.
            read_s = ~i_cmdsender_EMPTY;
            if (read_s) begin
               result_d = i_cmdsender_READDATA;
               state_d  = ST_FINISH;
            end else if ((CMDSENDER_TIMEOUT != 0) && (cnt_q == CNT_LIMIT)) begin
               flag_d  = 1'b1;
               state_d = ST_FINISH;
            end else if (CMDSENDER_TIMEOUT != 0) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_FINISH: begin
            done_s  = 1'b1;
            tout_s  = flag_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign o_cmdsender_WRITE     = write_s;
   assign o_cmdsender_WRITEDATA = wdata_s;
   assign o_cmdsender_READ      = read_s;
   assign o_cmdsender_RESULT    = result_q;
   assign o_cmdsender_DONE      = done_s;
   assign o_cmdsender_TIMEOUT   = tout_s;
   assign o_cmdsender_BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cmdsender_module.sv
// Self-checking bench for cmdsender_module: FIFO queues model the link side and
// transaction timing is predicted from push/pop counting.
module tb_cmdsender_module;

   localparam int TO = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [5:0] op;
   logic [7:0] da, db;
   logic       full, empty;
   logic [7:0] rdata;
   logic       o_write, o_read, o_done, o_tout, o_busy;
   logic [7:0] o_wdata, o_result;

   int passes = 0;
   int total  = 0;
   int fails  = 0;

   logic [7:0] rx_q[$];
   logic [7:0] tx_log[$];
   logic [7:0] last_res;

   cmdsender_module #(
      .NB_CMDSENDER_DATA(8),
      .NB_CMDSENDER_OP  (6),
      .CMDSENDER_TIMEOUT(TO)
   ) dut (
      .i_clk               (clk),
      .i_reset_n           (rst_n),
      .i_cmdsender_START   (start),
      .i_cmdsender_OP      (op),
      .i_cmdsender_DATAA   (da),
      .i_cmdsender_DATAB   (db),
      .i_cmdsender_FULL    (full),
      .i_cmdsender_EMPTY   (empty),
      .i_cmdsender_READDATA(rdata),
      .o_cmdsender_WRITE   (o_write),
      .o_cmdsender_WRITEDATA(o_wdata),
      .o_cmdsender_READ    (o_read),
      .o_cmdsender_RESULT  (o_result),
      .o_cmdsender_DONE    (o_done),
      .o_cmdsender_TIMEOUT (o_tout),
      .o_cmdsender_BUSY    (o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_rx();
      empty = (rx_q.size() == 0);
      rdata = empty ? 8'h00 : rx_q[0];
   endtask

   // One full request; expected timing comes from counting free TX cycles and RX availability.
   task automatic txn(input string nm, input logic [5:0] t_op, input logic [7:0] t_a,
                      input logic [7:0] t_b, input logic [7:0] t_res, input int res_avail,
                      input int full_start, input int full_len, input bit ign);
      int pushes, p3, entry, avail, rd_cyc, exp_done, done_cyc, reads;
      bit exp_to, clash, did_read, inject;
      logic [7:0] exp_res;
      pushes = 0;
      p3 = 0;
      for (int c = 1; c < 64 && pushes < 3; c++) begin
         if (!(c >= full_start && c < full_start + full_len)) begin
            pushes++;
            p3 = c;
         end
      end
      entry  = p3 + 1;
      inject = (rx_q.size() == 0);
      avail  = inject ? res_avail : 0;
      rd_cyc = (avail > entry) ? avail : entry;
      if (rd_cyc <= entry + TO) begin
         exp_to   = 1'b0;
         exp_done = rd_cyc + 1;
         exp_res  = inject ? t_res : rx_q[0];
      end else begin
         exp_to   = 1'b1;
         exp_done = entry + TO + 1;
         exp_res  = last_res;
      end
      tx_log.delete();
      reads = 0;
      done_cyc = -1;
      clash = 1'b0;
      for (int c = 0; c < 80 && done_cyc < 0; c++) begin
         start = (c == 0) || (ign && c == 3);
         if (c == 0) begin
            op = t_op; da = t_a; db = t_b;
         end else if (ign && c == 3) begin
            op = ~t_op; da = ~t_a; db = ~t_b;
         end
         full = (c >= full_start && c < full_start + full_len);
         if (inject && c == res_avail) rx_q.push_back(t_res);
         drive_rx();
         #1;
         if (c == 0) chk({nm, "_start_no_pop"}, {31'd0, o_read}, 32'd0);
         if (o_write) tx_log.push_back(o_wdata);
         if (o_write && o_read) clash = 1'b1;
         if (o_done) begin
            done_cyc = c;
            chk({nm, "_timeout_flag"}, {31'd0, o_tout}, {31'd0, exp_to});
            chk({nm, "_result"}, {24'd0, o_result}, {24'd0, exp_res});
         end
         did_read = o_read;
         @(posedge clk);
         #1;
         if (did_read) begin
            void'(rx_q.pop_front());
            reads++;
         end
      end
      start = 1'b0;
      full  = 1'b0;
      drive_rx();
      chk({nm, "_done_cycle"}, done_cyc, exp_done);
      chk({nm, "_push_count"}, tx_log.size(), 32'd3);
      chk({nm, "_frame"}, {8'd0, tx_log[0], tx_log[1], tx_log[2]}, {8'd0, 2'b00, t_op, t_a, t_b});
      chk({nm, "_pop_count"}, reads, exp_to ? 32'd0 : 32'd1);
      chk({nm, "_no_wr_rd_clash"}, {31'd0, clash}, 32'd0);
      #1;
      chk({nm, "_idle_after"}, {31'd0, o_busy}, 32'd0);
      if (!exp_to) last_res = exp_res;
   endtask

   initial begin
      int reads;
      bit did_read;
      rst_n = 1'b0; start = 1'b0; op = '0; da = '0; db = '0; full = 1'b0;
      last_res = 8'h00;
      drive_rx();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {18'd0, o_write, o_read, o_done, o_tout, o_busy, o_wdata, o_result},
          32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      txn("basic", 6'h20, 8'h05, 8'h03, 8'h08, 4, 99, 0, 1'b0);
      txn("tx_bp", 6'h20, 8'h05, 8'h03, 8'h2C, 4, 2, 3, 1'b0);
      txn("timeout", 6'h11, 8'h22, 8'h33, 8'h44, 1000, 99, 0, 1'b0);

      // Stale bytes while idle are drained without touching RESULT.
      rx_q.push_back(8'hA1);
      rx_q.push_back(8'hB2);
      reads = 0;
      for (int c = 0; c < 4; c++) begin
         drive_rx();
         #1;
         did_read = o_read;
         @(posedge clk);
         #1;
         if (did_read) begin
            void'(rx_q.pop_front());
            reads++;
         end
      end
      drive_rx();
      chk("drain_pops", reads, 32'd2);
      chk("drain_result_kept", {24'd0, o_result}, {24'd0, last_res});

      rx_q.push_back(8'h5A);
      txn("coincident", 6'h3F, 8'hC3, 8'h3C, 8'h77, 2, 99, 0, 1'b0);
      txn("ignore_busy", 6'h15, 8'h9A, 8'h6B, 8'hE1, 6, 99, 0, 1'b1);

      // Asynchronous reset in the middle of SEND_A.
      start = 1'b1; op = 6'h2A; da = 8'hDE; db = 8'hAD;
      drive_rx();
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_reset_send_a", {23'd0, o_write, o_wdata}, {23'd0, 1'b1, 8'hDE});
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", {18'd0, o_write, o_read, o_done, o_tout, o_busy, o_wdata, o_result},
          32'd0);
      last_res = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      txn("post_reset", 6'h07, 8'h81, 8'h42, 8'h99, 5, 99, 0, 1'b0);

      for (int i = 0; i < 10; i++) begin
         txn($sformatf("rand%0d", i), 6'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(1, 20)), int'($urandom_range(1, 6)), int'($urandom_range(0, 4)),
             1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
